// File: rtl/rtl_add_accumulator.sv
// Operand accumulator feeding a 16-bit ripple-carry adder.
// Groups of operands are summed and presented with a sticky carry/borrow flag.

module rtl_16bits_adder (
  input  logic [15:0] X,
  input  logic [15:0] Y,
  input  logic        cin,
  output logic [15:0] S,
  output logic        C
);

  logic [16:0] carry;

  assign carry[0] = cin;

  // One full-adder cell per bit, carry rippling upward.
  genvar i;
  generate
    for (i = 0; i < 16; i++) begin : g_fa
      assign S[i] = X[i] ^ Y[i] ^ carry[i];
      assign carry[i+1] = (X[i] & Y[i]) |
                          (X[i] & carry[i]) |
                          (Y[i] & carry[i]);
    end
  endgenerate

  assign C = carry[16];

endmodule

module rtl_add_accumulator #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  input  logic             in_sub,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_sum,
  output logic             out_ovf,
  output logic [CNT_W-1:0] out_count
);

  localparam logic [0:0] ST_ACC  = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE =
    {{(CNT_W-1){1'b0}}, 1'b1};

  logic [0:0]       state_q, state_d;
  logic [15:0]      acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      sum_q, sum_d;
  logic             oovf_q, oovf_d;
  logic [CNT_W-1:0] ocnt_q, ocnt_d;

  logic [15:0] add_y;
  logic [15:0] add_s;
  logic        add_c;
  logic        add_flag;
  logic        in_fire;
  logic        out_fire;

  // Subtraction is acc + ~data + 1; a missing carry is a borrow.
  assign add_y = in_sub ? ~in_data : in_data;

  rtl_16bits_adder u_adder (
    .X   (acc_q),
    .Y   (add_y),
    .cin (in_sub),
    .S   (add_s),
    .C   (add_c)
  );

  assign add_flag  = in_sub ? ~add_c : add_c;
  assign in_ready  = (state_q == ST_ACC);
  assign out_valid = (state_q == ST_HOLD);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  assign out_sum   = sum_q;
  assign out_ovf   = oovf_q;
  assign out_count = ocnt_q;

  // Next-state: accumulate on input handshake, clear on output handshake.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    oovf_d  = oovf_q;
    ocnt_d  = ocnt_q;
    unique case (1'b1)
      in_fire: begin
        acc_d = add_s;
        ovf_d = ovf_q | add_flag;
        cnt_d = (cnt_q == CNT_MAX) ?
                CNT_MAX : cnt_q + CNT_ONE;
        if (in_last) begin
          state_d = ST_HOLD;
          sum_d   = acc_d;
          oovf_d  = ovf_d;
          ocnt_d  = cnt_d;
        end
      end
      out_fire: begin
        state_d = ST_ACC;
        acc_d   = '0;
        ovf_d   = 1'b0;
        cnt_d   = '0;
      end
      default: ;
    endcase
  end

  // State and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ACC;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      oovf_q  <= 1'b0;
      ocnt_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      oovf_q  <= oovf_d;
      ocnt_q  <= ocnt_d;
    end
  end

endmodule

// File: tb/tb_rtl_add_accumulator.sv
// Self-checking bench for rtl_add_accumulator.
// Directed groups plus randomized traffic against a behavioural model.

module tb_rtl_add_accumulator;

  localparam int CNT_W = 8;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [15:0]      in_data = '0;
  logic             in_sub = 1'b0;
  logic             in_last = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [15:0]      out_sum;
  logic             out_ovf;
  logic [CNT_W-1:0] out_count;

  int checks = 0;
  int errors = 0;

  rtl_add_accumulator #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sub    (in_sub),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_ovf   (out_ovf),
    .out_count (out_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  // Behavioural model: plain integer arithmetic.
  bit m_hold;
  int m_acc, m_cnt, m_osum, m_ocnt;
  bit m_ovf, m_oovf;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_hold = 0; m_acc = 0; m_cnt = 0; m_ovf = 0;
      m_osum = 0; m_ocnt = 0; m_oovf = 0;
    end else if (!m_hold && in_valid) begin
      if (in_sub) begin
        if (int'(in_data) > m_acc) m_ovf = 1;
        m_acc = (m_acc - int'(in_data)) & 32'hFFFF;
      end else begin
        if (m_acc + int'(in_data) > 65535) m_ovf = 1;
        m_acc = (m_acc + int'(in_data)) & 32'hFFFF;
      end
      if (m_cnt < CMAX) m_cnt++;
      if (in_last) begin
        m_hold = 1;
        m_osum = m_acc; m_oovf = m_ovf; m_ocnt = m_cnt;
      end
    end else if (m_hold && out_ready) begin
      m_hold = 0; m_acc = 0; m_cnt = 0; m_ovf = 0;
    end
  end

  // Compare DUT against model every cycle, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("m_in_ready", in_ready, !m_hold);
      chk("m_out_valid", out_valid, m_hold);
      if (m_hold) begin
        chk("m_out_sum", out_sum, m_osum);
        chk("m_out_ovf", out_ovf, m_oovf);
        chk("m_out_count", out_count, m_ocnt);
      end
    end
  end

  // Present one operand; returns at the negedge after acceptance.
  task automatic send(input logic [15:0] d,
                      input logic s, input logic l);
    int n = 0;
    in_valid = 1'b1; in_data = d;
    in_sub = s; in_last = l;
    while (!in_ready && n < 50) begin
      @(negedge clk); n++;
    end
    if (n >= 50) chk("send_timeout", 1, 0);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic expect_out(input string nm,
                            input logic [15:0] s,
                            input logic o,
                            input int c);
    chk({nm, "_valid"}, out_valid, 1);
    chk({nm, "_sum"}, out_sum, s);
    chk({nm, "_ovf"}, out_ovf, o);
    chk({nm, "_cnt"}, out_count, c);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_sum", out_sum, 0);
    chk("rst_cnt", out_count, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset mid-group.
    send(16'h0100, 0, 0);
    send(16'h0200, 0, 0);
    send(16'h0300, 0, 0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_ready", in_ready, 1);
    chk("mid_rst_sum", out_sum, 0);
    chk("mid_rst_cnt", out_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    send(16'h0005, 0, 1);
    expect_out("after_rst", 16'h0005, 0, 1);
    @(negedge clk);

    // Plain add group, result visible one cycle.
    send(16'h1234, 0, 0);
    send(16'h0101, 0, 0);
    send(16'h0002, 0, 1);
    expect_out("add", 16'h1337, 0, 3);
    @(negedge clk);
    chk("add_pulse", out_valid, 0);

    send(16'hFFFF, 0, 0);
    send(16'h0001, 0, 1);
    expect_out("add_ovf", 16'h0000, 1, 2);
    @(negedge clk);

    send(16'h0003, 0, 0);
    send(16'h0005, 1, 1);
    expect_out("sub_brw", 16'hFFFE, 1, 2);
    @(negedge clk);

    send(16'h0010, 0, 0);
    send(16'h0004, 1, 1);
    expect_out("sub_ok", 16'h000C, 0, 2);
    @(negedge clk);

    send(16'h0000, 0, 0);
    send(16'h0001, 1, 1);
    expect_out("sub_wrap", 16'hFFFF, 1, 2);
    @(negedge clk);

    // Backpressure with a pending operand.
    out_ready = 1'b0;
    send(16'h0042, 0, 1);
    in_valid = 1'b1; in_data = 16'h0007;
    in_sub = 1'b0; in_last = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("bp_ready", in_ready, 0);
      chk("bp_sum", out_sum, 16'h0042);
      @(negedge clk);
    end
    out_ready = 1'b1;
    chk("bp_hold_valid", out_valid, 1);
    @(negedge clk);
    chk("bp_rel_ready", in_ready, 1);
    chk("bp_rel_valid", out_valid, 0);
    @(negedge clk);
    in_valid = 1'b0;
    expect_out("bp_next", 16'h0007, 0, 1);
    @(negedge clk);

    // Counter saturation.
    for (int i = 1; i <= 300; i++)
      send(16'h0001, 0, (i == 300));
    expect_out("sat", 16'h012C, 0, 255);
    @(negedge clk);

    // Randomized traffic; the model checks every cycle.
    for (int i = 0; i < 2500; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 5))
        0: in_data = 16'hFFFF;
        1: in_data = 16'h0000;
        default: in_data = 16'($urandom);
      endcase
      in_sub    = 1'($urandom);
      in_last   = ($urandom_range(0, 5) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      if (i == 1200) rst_n = 1'b0;
      if (i == 1202) rst_n = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
